// File: rtl/arithmetic_pkg.sv
// Shared arithmetic definitions for the ripple adder / serial subtractor family.
package arithmetic_pkg;

    localparam int ARITH_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: D = X ^ Y ^ Bi, Bo = (~X & Y) | (~(X ^ Y) & Bi).
module full_subtractor (
    output logic D,
    output logic Bo,
    input  logic X,
    input  logic Y,
    input  logic Bi
);

    logic xy_s;
    logic nx_s;
    logic nxy_s;
    logic gen_s;
    logic prop_s;

    xor g_xy   (xy_s, X, Y);
    xor g_d    (D, xy_s, Bi);
    not g_nx   (nx_s, X);
    and g_gen  (gen_s, nx_s, Y);
    not g_nxy  (nxy_s, xy_s);
    and g_prop (prop_s, nxy_s, Bi);
    or  g_bo   (Bo, gen_s, prop_s);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor D = X - Y - Bin, LSB first, one bit per clock behind a
// start/done handshake; a single full_subtractor cell is reused every cycle.
module serial_ripple_subtractor
    import arithmetic_pkg::*;
#(
    parameter int N = ARITH_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         Bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic         zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  xs_q, xs_d;
    logic [N-1:0]  ys_q, ys_d;
    logic [N-1:0]  rs_q, rs_d;
    logic          b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  res_q, res_d;
    logic          bout_q, bout_d;
    logic          zero_q, zero_d;

    logic          d_bit_s;
    logic          bo_s;
    logic [N-1:0]  rs_shift_s;

    full_subtractor u_cell (
        .D  (d_bit_s),
        .Bo (bo_s),
        .X  (xs_q[0]),
        .Y  (ys_q[0]),
        .Bi (b_q)
    );

    // Result bits arrive LSB first, so each new bit enters at the MSB.
    assign rs_shift_s = {d_bit_s, rs_q[N-1:1]};

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        rs_d    = rs_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    xs_d    = X;
                    ys_d    = Y;
                    b_d     = Bin;
                    rs_d    = {N{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                xs_d  = xs_q >> 1;
                ys_d  = ys_q >> 1;
                rs_d  = rs_shift_s;
                b_d   = bo_s;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    res_d   = rs_shift_s;
                    bout_d  = bo_s;
                    zero_d  = (rs_shift_s == {N{1'b0}});
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            xs_q    <= {N{1'b0}};
            ys_q    <= {N{1'b0}};
            rs_q    <= {N{1'b0}};
            b_q     <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= {N{1'b0}};
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            rs_q    <= rs_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = res_q;
    assign Bout = bout_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed and exhaustive checks of serial_ripple_subtractor at N=4 and N=8.
module tb_serial_ripple_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] x4 = 4'd0, y4 = 4'd0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4, zero4;
    logic [3:0] d4;

    logic       start8 = 1'b0;
    logic [7:0] x8 = 8'd0, y8 = 8'd0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8, zero8;
    logic [7:0] d8;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    serial_ripple_subtractor #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .X(x4), .Y(y4), .Bin(bin4),
        .busy(busy4), .done(done4), .D(d4), .Bout(bout4), .zero(zero4)
    );

    serial_ripple_subtractor #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .X(x8), .Y(y8), .Bin(bin8),
        .busy(busy8), .done(done8), .D(d8), .Bout(bout8), .zero(zero8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one N=4 operation; checks latency, result, borrow and zero flag.
    task automatic op4(input logic [3:0] xa, input logic [3:0] ya, input logic ba, input bit full);
        logic [4:0] diff;
        int cyc;
        bit seen;
        diff = {1'b0, xa} - {1'b0, ya} - {4'd0, ba};
        x4 = xa; y4 = ya; bin4 = ba; start4 = 1'b1;
        step();
        start4 = 1'b0;
        x4 = ~xa; y4 = ~ya; bin4 = ~ba;
        if (full) chk("busy_after_start", {31'd0, busy4}, 32'd1);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 12) begin
            step();
            cyc++;
            seen = done4;
        end
        chk("op4_latency", cyc, seen ? 32'd4 : 32'd99);
        chk("op4_D", {28'd0, d4}, {28'd0, diff[3:0]});
        chk("op4_Bout", {31'd0, bout4}, {31'd0, diff[4]});
        if (full) begin
            chk("op4_zero", {31'd0, zero4}, {31'd0, (diff[3:0] == 4'd0)});
            chk("op4_busy_at_done", {31'd0, busy4}, 32'd0);
            step();
            chk("op4_done_one_cycle", {31'd0, done4}, 32'd0);
        end else begin
            step();
        end
    endtask

    task automatic op8(input logic [7:0] xa, input logic [7:0] ya, input logic ba);
        logic [8:0] diff;
        int cyc;
        bit seen;
        diff = {1'b0, xa} - {1'b0, ya} - {8'd0, ba};
        x8 = xa; y8 = ya; bin8 = ba; start8 = 1'b1;
        step();
        start8 = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            step();
            cyc++;
            seen = done8;
        end
        chk("op8_latency", cyc, seen ? 32'd8 : 32'd99);
        chk("op8_D", {24'd0, d8}, {24'd0, diff[7:0]});
        chk("op8_Bout", {31'd0, bout8}, {31'd0, diff[8]});
        chk("op8_zero", {31'd0, zero8}, {31'd0, (diff[7:0] == 8'd0)});
        step();
    endtask

    initial begin
        logic [3:0] bx [3];
        logic [3:0] by [3];
        logic       bb [3];
        logic [3:0] bd [3];
        int cyc, k, npulse;

        #2;
        chk("rst_busy", {31'd0, busy4}, 32'd0);
        chk("rst_done", {31'd0, done4}, 32'd0);
        chk("rst_D", {28'd0, d4}, 32'd0);
        chk("rst_Bout_zero", {30'd0, bout4, zero4}, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        op4(4'd5, 4'd3, 1'b0, 1'b1);
        op4(4'd3, 4'd5, 1'b0, 1'b1);
        chk("3m5_D", {28'd0, d4}, 32'd14);
        op4(4'd0, 4'd0, 1'b1, 1'b1);
        chk("0m0m1_D", {28'd0, d4}, 32'd15);
        op4(4'd9, 4'd9, 1'b0, 1'b1);
        chk("9m9_zero", {31'd0, zero4}, 32'd1);

        // start while busy is ignored
        x4 = 4'd12; y4 = 4'd4; bin4 = 1'b0; start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        x4 = 4'd1; y4 = 4'd1; start4 = 1'b1;
        step();
        start4 = 1'b0;
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            if (done4) npulse++;
            step();
        end
        chk("ignored_start_pulses", npulse, 32'd1);
        chk("ignored_start_D", {28'd0, d4}, 32'd8);

        // back-to-back with start held high
        bx[0] = 4'd6;  by[0] = 4'd1; bb[0] = 1'b0; bd[0] = 4'd5;
        bx[1] = 4'd2;  by[1] = 4'd7; bb[1] = 1'b0; bd[1] = 4'd11;
        bx[2] = 4'd15; by[2] = 4'd0; bb[2] = 1'b1; bd[2] = 4'd14;
        x4 = bx[0]; y4 = by[0]; bin4 = bb[0]; start4 = 1'b1;
        step();
        k = 0;
        cyc = 0;
        while (k < 3 && cyc < 40) begin
            step();
            cyc++;
            if (done4) begin
                chk("b2b_cycle", cyc, 4 + 5 * k);
                chk("b2b_D", {28'd0, d4}, {28'd0, bd[k]});
                k++;
                if (k < 3) begin
                    x4 = bx[k]; y4 = by[k]; bin4 = bb[k];
                end else begin
                    start4 = 1'b0;
                end
            end else if (k > 0) begin
                chk("b2b_D_hold", {28'd0, d4}, {28'd0, bd[k-1]});
                chk("b2b_busy", {31'd0, busy4}, 32'd1);
            end else begin
                chk("b2b_busy_first", {31'd0, busy4}, 32'd1);
            end
        end
        chk("b2b_count", k, 32'd3);
        start4 = 1'b0;
        step();
        step();

        // reset in the middle of RUN
        x4 = 4'd7; y4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy4}, 32'd0);
        chk("midrst_done", {31'd0, done4}, 32'd0);
        chk("midrst_D", {28'd0, d4}, 32'd0);
        chk("midrst_Bout_zero", {30'd0, bout4, zero4}, 32'd0);
        step();
        rst = 1'b0;
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done4) npulse++;
        end
        chk("midrst_no_done", npulse, 32'd0);
        op4(4'd7, 4'd2, 1'b0, 1'b1);
        chk("after_rst_D", {28'd0, d4}, 32'd5);

        // exhaustive N=4
        for (int xi = 0; xi < 16; xi++)
            for (int yi = 0; yi < 16; yi++)
                for (int bi = 0; bi < 2; bi++)
                    op4(4'(xi), 4'(yi), 1'(bi), 1'b0);

        // random subset N=8 plus corners
        op8(8'd0, 8'd0, 1'b1);
        op8(8'd255, 8'd255, 1'b0);
        op8(8'd128, 8'd127, 1'b1);
        for (int i = 0; i < 150; i++)
            op8(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
Bit-serial subtractor that computes D = X - Y - Bin over N clock cycles, one bit per cycle, LSB first.
- A single one-bit full-subtractor cell is reused every cycle, with the borrow held in a flip-flop between bits.
- It is the inverse-operation companion to the 4-bit ripple adder: same operand widths and a carry/borrow-in/out convention.
- It sits in the datapath as a low-area arithmetic unit behind a start/done handshake.

Parameters:
N, 4, operand and result width in bits (N >= 2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
X  input  N  minuend; captured on the accepted start edge
Y  input  N  subtrahend; captured on the accepted start edge
Bin  input  1  borrow-in; captured on the accepted start edge
busy  output  1  high while an operation is in progress (RUN)
done  output  1  one-cycle pulse; D/Bout/zero valid and updated
D  output  N  difference, registered, held until the next completion
Bout  output  1  final borrow-out (1 = X < Y + Bin, unsigned)
zero  output  1  high when D == 0, updated together with D

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; busy=0, done=0, D=0, Bout=0, zero=0.
  - Shift registers, borrow flip-flop and bit counter are cleared.
- States: IDLE, RUN. No separate DONE state.
- IDLE:
  - busy=0.
  - With start=1 at a rising edge: load X into XS, Y into YS, Bin into the borrow flop b, counter cnt=0; go to RUN.
  - With start=0: remain in IDLE.
- RUN (busy=1), on each edge:
  - d = XS[0] ^ YS[0] ^ b.
  - b <= (~XS[0] & YS[0]) | (~(XS[0] ^ YS[0]) & b).
  - XS and YS shift right by 1.
  - d shifts into the MSB of the result shift register RS.
  - cnt increments.
- Completion, on the edge where cnt == N-1:
  - D <= final RS, including the current d.
  - Bout <= new borrow.
  - zero <= (final RS == 0).
  - done <= 1; state goes to IDLE.
- Latency: start accepted at edge 0 → bit i is processed at edge i+1 → done is high during the cycle following edge N. Exactly N cycles from start to done; throughput is one operation per N+1 cycles.
- done is cleared on the next edge; it is never high for more than one cycle.
- Back-to-back operation: start held high during the done cycle is accepted at that edge (state is already IDLE), and busy rises again.
- start while busy=1 is ignored; the captured operands are unaffected.
- Changes on X/Y/Bin after acceptance have no effect on the current operation.
- D, Bout and zero change only at completion; they stay stable throughout RUN and IDLE.
- Arithmetic:
  - Unsigned modulo 2^N: D = (X - Y - Bin) mod 2^N.
  - Bout = 1 iff X < Y + Bin.
  - For N=4: 0 - 0 - 1 gives D=15, Bout=1.
- Reset asserted mid-RUN:
  - The operation is aborted immediately; done is never asserted for it.
  - Outputs return to reset values.
  - After reset deasserts, the first start begins a clean operation.
- The counter width is clog2(N); it never wraps past N-1 within an operation.

Decomposition:
- Shared package, arithmetic_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_RUN=1'b1.
  - Default width constant ARITH_W=4, shared with the ripple adder.
- Sub-module full_subtractor:
  - Ports D, Bo, X, Y, Bi.
  - Structural one-bit cell built from xor/and/or/not primitives, mirroring the existing full adder.
  - Instantiated once.
- The top level holds the FSM, shift registers, borrow flop, counter and output registers.

Test Plan:
- X=5, Y=3, Bin=0, start pulsed for one cycle → busy for 4 cycles; done pulses on the cycle after the 4th edge; D=2, Bout=0, zero=0.
- X=3, Y=5, Bin=0 → D=14, Bout=1. Then X=0, Y=0, Bin=1 → D=15, Bout=1. Then X=9, Y=9, Bin=0 → D=0, Bout=0, zero=1.
- Start X=12, Y=4; on cycle 2 pulse start with X=1, Y=1 → ignored; the result is D=8, and exactly one done pulse is produced.
- Hold start=1 continuously with operands changed on each done cycle → completions every 5 cycles with correct results; D holds between completions.
- Assert rst during cycle 2 of RUN (X=7, Y=2) → busy, done, D, Bout and zero go to 0 immediately with no done pulse. After release, start X=7, Y=2 → D=5.
- Exhaustive check over all 512 (X, Y, Bin) combinations for N=4 against the reference model (X - Y - Bin) mod 16 and its borrow.
- Repeat the exhaustive check with a random subset at N=8.
